// File: rtl/pulse_pkg.sv
// Shared definitions for the pulse stretcher: FSM state encoding,
// default timing constants and the counter sizing helper.
package pulse_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    STRETCH = 2'b01,
    HOLDOFF = 2'b10
  } stateT;

  localparam int DEFAULT_STRETCH_CYCLES = 4;
  localparam int DEFAULT_GAP_CYCLES     = 2;

  // One counter serves both phases, so it must hold the larger of the two loads.
  function automatic int counterWidth(input int stretchCycles, input int gapCycles);
    int maxCycles;
    maxCycles = (stretchCycles > gapCycles) ? stretchCycles : gapCycles;
    return $clog2(maxCycles + 1);
  endfunction

endpackage

// File: rtl/pulse_down_counter.sv
// Loadable down-counter that saturates at zero and flags the terminal value.
module pulse_down_counter #(
  parameter int WIDTH = 3
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             load,
  input  logic [WIDTH-1:0] loadValue,
  output logic             isZero
);

  logic [WIDTH-1:0] count;

  // A load wins over counting; once at zero the count holds there.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      count <= '0;
    end else if (load) begin
      count <= loadValue;
    end else if (count != '0) begin
      count <= count - WIDTH'(1);
    end
  end

  assign isZero = (count == '0);

endmodule

// File: rtl/pulse_stretcher.sv
// Stretches single-cycle event pulses into fixed-width highs separated by a
// guaranteed low gap, with a one-deep queue and a sticky overrun flag.
module pulse_stretcher
  import pulse_pkg::*;
#(
  parameter int STRETCH_CYCLES = DEFAULT_STRETCH_CYCLES,
  parameter int GAP_CYCLES     = DEFAULT_GAP_CYCLES,
  parameter int RETRIGGER      = 0
) (
  input  logic Clk,
  input  logic Reset,
  input  logic DataIn,
  input  logic ClearOverrun,
  output logic DataOut,
  output logic Busy,
  output logic Overrun
);

  localparam int CNT_W = counterWidth(STRETCH_CYCLES, GAP_CYCLES);
  localparam logic [CNT_W-1:0] STRETCH_LOAD = CNT_W'(STRETCH_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD     = CNT_W'(GAP_CYCLES - 1);
  localparam logic             RETRIG_ON    = (RETRIGGER != 0);

  generate
    if (STRETCH_CYCLES < 1) begin : gBadStretch
      $error("pulse_stretcher: STRETCH_CYCLES must be at least 1");
    end
    if (GAP_CYCLES < 1) begin : gBadGap
      $error("pulse_stretcher: GAP_CYCLES must be at least 1");
    end
  endgenerate

  stateT            state;
  stateT            nextState;
  logic             pending;
  logic             nextPending;
  logic             overrunSet;
  logic             cntLoad;
  logic [CNT_W-1:0] cntLoadValue;
  logic             cntZero;

  pulse_down_counter #(
    .WIDTH (CNT_W)
  ) uCounter (
    .Clk       (Clk),
    .Reset     (Reset),
    .load      (cntLoad),
    .loadValue (cntLoadValue),
    .isZero    (cntZero)
  );

  always_comb begin
    nextState    = state;
    nextPending  = pending;
    overrunSet   = 1'b0;
    cntLoad      = 1'b0;
    cntLoadValue = STRETCH_LOAD;
    case (state)
      IDLE: begin
        if (DataIn) begin
          nextState = STRETCH;
          cntLoad   = 1'b1;
        end
      end
      STRETCH: begin
        if (DataIn && RETRIG_ON) begin
          cntLoad = 1'b1;
        end else begin
          if (DataIn) begin
            if (pending) overrunSet  = 1'b1;
            else         nextPending = 1'b1;
          end
          if (cntZero) begin
            nextState    = HOLDOFF;
            cntLoad      = 1'b1;
            cntLoadValue = GAP_LOAD;
          end
        end
      end
      HOLDOFF: begin
        if (cntZero) begin
          // A fresh event arriving as the queued one is launched takes its queue slot.
          if (pending || DataIn) begin
            nextState   = STRETCH;
            cntLoad     = 1'b1;
            nextPending = pending && DataIn;
          end else begin
            nextState = IDLE;
          end
        end else if (DataIn) begin
          if (pending) overrunSet  = 1'b1;
          else         nextPending = 1'b1;
        end
      end
      default: begin
        nextState   = IDLE;
        nextPending = 1'b0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they are true registers.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state   <= IDLE;
      pending <= 1'b0;
      DataOut <= 1'b0;
      Busy    <= 1'b0;
      Overrun <= 1'b0;
    end else begin
      state   <= nextState;
      pending <= nextPending;
      DataOut <= (nextState == STRETCH);
      Busy    <= (nextState != IDLE);
      Overrun <= overrunSet || (Overrun && !ClearOverrun);
    end
  end

endmodule

// File: tb/tb_pulse_stretcher.sv
// Directed checks of pulse_stretcher in queueing (dutA) and retrigger (dutB) modes.
module tb_pulse_stretcher;

  logic clk;
  logic reset;
  logic dataIn;
  logic clearOverrun;
  logic dataOutA, busyA, overrunA;
  logic dataOutB, busyB, overrunB;
  int   total;
  int   bad;

  pulse_stretcher #(.STRETCH_CYCLES(4), .GAP_CYCLES(2), .RETRIGGER(0)) dutA (
    .Clk          (clk),
    .Reset        (reset),
    .DataIn       (dataIn),
    .ClearOverrun (clearOverrun),
    .DataOut      (dataOutA),
    .Busy         (busyA),
    .Overrun      (overrunA)
  );

  pulse_stretcher #(.STRETCH_CYCLES(4), .GAP_CYCLES(2), .RETRIGGER(1)) dutB (
    .Clk          (clk),
    .Reset        (reset),
    .DataIn       (dataIn),
    .ClearOverrun (clearOverrun),
    .DataOut      (dataOutB),
    .Busy         (busyB),
    .Overrun      (overrunB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic observed, input logic expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0b expected=%0b at %0t", tag, observed, expected, $time);
    end
  endtask

  // Inputs change at a falling edge, are sampled at the next rising edge,
  // and outputs are observed at the falling edge that follows.
  task automatic applyStimulus(input logic din, input logic clr);
    dataIn       = din;
    clearOverrun = clr;
    @(negedge clk);
  endtask

  task automatic doReset();
    dataIn       = 1'b0;
    clearOverrun = 1'b0;
    reset        = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  // Vectors are read left to right in time; sel picks dutB when set.
  task automatic runSeq(input string tag, input int n, input logic sel,
                        input logic [31:0] din, input logic [31:0] clr,
                        input logic [31:0] expOut, input logic [31:0] expBusy,
                        input logic [31:0] expOvr);
    for (int i = 0; i < n; i++) begin
      applyStimulus(din[n-1-i], clr[n-1-i]);
      checkOutput($sformatf("%s.out[%0d]", tag, i + 1), sel ? dataOutB : dataOutA, expOut[n-1-i]);
      checkOutput($sformatf("%s.busy[%0d]", tag, i + 1), sel ? busyB : busyA, expBusy[n-1-i]);
      checkOutput($sformatf("%s.ovr[%0d]", tag, i + 1), sel ? overrunB : overrunA, expOvr[n-1-i]);
    end
  endtask

  initial begin
    total        = 0;
    bad          = 0;
    reset        = 1'b0;
    dataIn       = 1'b0;
    clearOverrun = 1'b0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("rst.out", dataOutA, 1'b0);
    checkOutput("rst.busy", busyA, 1'b0);
    checkOutput("rst.ovr", overrunA, 1'b0);

    // Asynchronous reset in the middle of a stretch
    applyStimulus(1'b1, 1'b0);
    checkOutput("async.pre.out", dataOutA, 1'b1);
    dataIn = 1'b0;
    #2 reset = 1'b0;
    #1;
    checkOutput("async.out", dataOutA, 1'b0);
    checkOutput("async.busy", busyA, 1'b0);
    checkOutput("async.ovr", overrunA, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Single pulse
    doReset();
    runSeq("single", 9, 1'b0, 32'b100000000, 32'b0,
           32'b111100000, 32'b111111000, 32'b0);

    // Two pulses two cycles apart: one queued, no overrun
    doReset();
    runSeq("queue", 14, 1'b0, 32'b10100000000000, 32'b0,
           32'b11110011110000, 32'b11111111111100, 32'b0);

    // Three back-to-back pulses: third one is lost
    doReset();
    runSeq("overrun", 14, 1'b0, 32'b11100000000000, 32'b0,
           32'b11110011110000, 32'b11111111111100, 32'b00111111111111);

    // New overrun together with a clear: set dominates
    runSeq("setdom", 14, 1'b0, 32'b11100000000000, 32'b00100000000000,
           32'b11110011110000, 32'b11111111111100, 32'b11111111111111);

    // Clear on its own
    runSeq("clear", 2, 1'b0, 32'b00, 32'b10, 32'b00, 32'b00, 32'b00);

    // Retrigger mode extends the high level
    doReset();
    runSeq("retrig", 11, 1'b1, 32'b10010000000, 32'b0,
           32'b11111110000, 32'b11111111100, 32'b0);

    // Event on the final holdoff cycle while one is already queued
    doReset();
    runSeq("lastgap", 20, 1'b0, 32'b10100010000000000000, 32'b0,
           32'b11110011110011110000, 32'b11111111111111111100, 32'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
